// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential shift-and-add multiplier that drives the datapath ALU
module alu_mul_seq #(
   parameter int         W       = 8,
   parameter logic [2:0] R_ADD   = 3'd1,
   parameter logic [2:0] R_SHIFT = 3'd2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] mcand,
   input  logic [W-1:0] mplier,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] product,
   output logic         zero,
   output logic         parity,
   output logic         odd,
   output logic [2:0]   alu_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADD   = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]   state;
   logic [1:0]   state_nx;
   logic [W-1:0] acc;
   logic [W-1:0] mc;
   logic [W-1:0] mp;
   logic [W-1:0] mp_sh;

   assign mp_sh = mp >> 1;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (mplier == '0)
                  state_nx = S_DONE;
               else if (mplier[0])
                  state_nx = S_ADD;
               else
                  state_nx = S_SHIFT;
            end
         end
         S_ADD:   state_nx = S_SHIFT;
         S_SHIFT: begin
            if (mp_sh == '0)
               state_nx = S_DONE;
            else if (mp[1])
               state_nx = S_ADD;
            else
               state_nx = S_SHIFT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      alu_op = 3'd0;
      alu_a  = '0;
      alu_b  = '0;
      case (state)
         S_ADD: begin
            alu_op = R_ADD;
            alu_a  = acc;
            alu_b  = mc;
         end
         S_SHIFT: begin
            alu_op = R_SHIFT;
            alu_a  = mc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         acc     <= '0;
         mc      <= '0;
         mp      <= '0;
         product <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mc  <= mcand;
                  mp  <= mplier;
                  acc <= '0;
               end
            end
            S_ADD:   acc <= alu_out;
            S_SHIFT: begin
               mc <= alu_out;
               mp <= mp_sh;
            end
            default: ;
         endcase
         // acc still holds the previous result when a zero multiplier skips straight to DONE
         if (state != S_DONE && state_nx == S_DONE)
            product <= (state == S_IDLE) ? '0 : acc;
      end
   end

   assign busy   = (state != S_IDLE);
   assign done   = (state == S_DONE);
   assign zero   = (product == '0);
   assign parity = ^product;
   assign odd    = product[0];

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - vector table, random and corner-case checks for alu_mul_seq
module tb_alu_mul_seq;

   localparam logic [2:0] R_ADD   = 3'd1;
   localparam logic [2:0] R_SHIFT = 3'd2;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] mcand;
   logic [7:0] mplier;
   logic       busy;
   logic       done;
   logic [7:0] product;
   logic       zero;
   logic       parity;
   logic       odd;
   logic [2:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      int         lat;
      logic       z;
      logic       par;
      logic       o;
   } vec_t;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } alu_t;

   alu_mul_seq #(.W(8), .R_ADD(R_ADD), .R_SHIFT(R_SHIFT)) dut (
      .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .product(product), .zero(zero), .parity(parity),
      .odd(odd), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
   );

   always #5 clk = ~clk;

   // ALU stand-in: add and shift-left-by-one
   always_comb begin
      alu_out = 8'h00;
      if (alu_op == R_ADD)
         alu_out = alu_a + alu_b;
      else if (alu_op == R_SHIFT)
         alu_out = alu_a << 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // one multiply from an IDLE negedge; elat<0 means take latency from the op model
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input int elat_in);
      alu_t q[$];
      int   msb;
      int   elat;
      int   lat;
      int   seq_bad;
      bit   got;
      int   ai;
      int   bi;
      logic [7:0] ep;
      msb = -1;
      ai  = int'(a);
      bi  = int'(b);
      for (int i = 0; i < 8; i++)
         if (b[i]) msb = i;
      for (int i = 0; i <= msb; i++) begin
         logic [7:0] mc_i;
         logic [7:0] acc_i;
         mc_i  = 8'((ai * (1 << i)) % 256);
         acc_i = 8'((ai * (bi % (1 << i))) % 256);
         if (b[i]) q.push_back('{R_ADD, acc_i, mc_i});
         q.push_back('{R_SHIFT, mc_i, 8'd0});
      end
      elat = (elat_in < 0) ? q.size() + 1 : elat_in;
      ep   = 8'((ai * bi) % 256);
      seq_bad = 0;
      got = 1'b0;
      lat = 0;
      mcand = a; mplier = b; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            lat = c;
         end else begin
            if (c - 1 < q.size()) begin
               if (alu_op !== q[c-1].op || alu_a !== q[c-1].a || alu_b !== q[c-1].b)
                  seq_bad++;
            end else
               seq_bad++;
            if (busy !== 1'b1) seq_bad++;
         end
      end
      check({name, "_done_seen"}, 32'(got), 32'd1);
      if (got) begin
         check({name, "_latency"}, lat, elat);
         check({name, "_product"}, 32'(product), 32'(ep));
         check({name, "_flags"}, {zero, parity, odd}, {ep == 8'h00, ^ep, ep[0]});
         check({name, "_alu_idle_in_done"}, {alu_op, alu_a, alu_b}, 32'd0);
         check({name, "_alu_seq_errs"}, seq_bad, 0);
      end
      @(negedge clk);
      check({name, "_idle_after"}, {busy, done}, 2'b00);
   endtask

   initial begin
      vec_t vt[5];
      int   dn[$];
      bit   got;
      int   lat;
      logic [7:0] held;

      vt[0] = '{8'h03, 8'h05, 8'h0F, 6,  1'b0, 1'b0, 1'b1};
      vt[1] = '{8'hFF, 8'hFF, 8'h01, 17, 1'b0, 1'b1, 1'b1};
      vt[2] = '{8'h10, 8'h10, 8'h00, 7,  1'b1, 1'b0, 1'b0};
      vt[3] = '{8'h5A, 8'h00, 8'h00, 1,  1'b1, 1'b0, 1'b0};
      vt[4] = '{8'h00, 8'h81, 8'h00, 11, 1'b1, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; mcand = 8'h00; mplier = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_outputs", {product, zero, parity, odd, busy, done, alu_op},
            {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
      reset = 1'b0;
      @(negedge clk);

      foreach (vt[i]) begin
         run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].lat);
         check($sformatf("vec%0d_table", i), {product, zero, parity, odd},
               {vt[i].p, vt[i].z, vt[i].par, vt[i].o});
      end

      for (int i = 0; i < 30; i++)
         run_op($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1);

      // product holds while idle
      held = product;
      repeat (3) @(negedge clk);
      check("product_hold", 32'(product), 32'(held));

      // start pulsed while busy is ignored
      mcand = 8'd7; mplier = 8'd9; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mcand = 8'd1; mplier = 8'd1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      got = 1'b0; lat = 0;
      for (int c = 3; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; lat = c; end
      end
      check("busy_start_done", 32'(got), 32'd1);
      check("busy_start_latency", lat, 7);
      check("busy_start_product", 32'(product), 32'd63);
      @(negedge clk);
      check("busy_start_no_requeue", {busy, done}, 2'b00);

      // start held high: back-to-back with one idle cycle between
      mcand = 8'd5; mplier = 8'd1; start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done) dn.push_back(c);
      end
      start = 1'b0;
      check("b2b_count", dn.size(), 3);
      if (dn.size() >= 2) begin
         check("b2b_first", dn[0], 3);
         check("b2b_second", dn[1], 7);
      end
      check("b2b_product", 32'(product), 32'd5);
      @(negedge clk);
      check("b2b_idle", 32'(busy), 32'd0);

      // reset mid-operation
      mcand = 8'hFF; mplier = 8'hFF; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_outputs", {product, zero, parity, odd, busy, done, alu_op, alu_a, alu_b},
            {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00});
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_op("after_reset", 8'd2, 8'd3, 5);
      check("after_reset_val", 32'(product), 32'h06);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
